mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, giving the cycles in BUSY before a timeout abort (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_I  input  1  instruction-fetch request, held high until ack_I.
REQ-005 SHALL have port addr_I  input  32  instruction-fetch address, stable while req_I is high.
REQ-006 SHALL have port ack_I  output  1  one-cycle pulse: fetch complete, rdata_I valid.
REQ-007 SHALL have port rdata_I  output  32  fetched instruction word.
REQ-008 SHALL have port req_D  input  1  data request, held high until ack_D.
REQ-009 SHALL have port wen_D  input  1  1 = write, 0 = read, stable while req_D is high.
REQ-010 SHALL have ports addr_D and wdata_D  input  32 each  data address and write data, stable while req_D is high.
REQ-011 SHALL have port ack_D  output  1  one-cycle pulse: data access complete.
REQ-012 SHALL have port rdata_D  output  32  read data; valid with ack_D on reads.
REQ-013 SHALL have ports mem_cen, mem_wen  output  1 each  memory access enable and write enable.
REQ-014 SHALL have ports mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-015 SHALL have port mem_rdata  input  32  memory read data.
REQ-016 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-017 SHALL have port err  output  1  sticky timeout flag (constant 0 without ARB_TIMEOUT_EN).

Function
REQ-018 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-019 SHALL, in IDLE with any request high, grant one requester, latch owner, addr, wdata and wen at the clock edge, and move to BUSY.
REQ-020 SHALL grant the requester not served last when req_I and req_D are both high in the same IDLE cycle (round-robin), and grant D after reset.
REQ-021 SHALL grant a lone requester immediately, regardless of the round-robin pointer.
REQ-022 SHALL, in BUSY, drive mem_cen=1 and mem_addr, mem_wdata, mem_wen from the latched values; in IDLE and DONE mem_cen=mem_wen=0, and mem_addr and mem_wdata hold their last values.
REQ-023 SHALL, in BUSY with mem_ready=1, register mem_rdata into the owner's rdata, update the round-robin pointer to the owner, and move to DONE.
REQ-024 SHALL assert ack of the owner only, for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL ignore all requests in BUSY and DONE; a request held through DONE is re-evaluated in the following IDLE cycle.
REQ-026 SHALL give minimum latency of 2 cycles from request edge to ack (request sampled at edge n, mem_ready in the BUSY cycle, ack in the cycle after edge n+1).
REQ-027 SHALL hold rdata_I and rdata_D until that port's next completion; a write completion leaves rdata_D unchanged.
REQ-028 SHALL pass data and addresses unmodified (no byte swap).

Reset
REQ-029 SHALL, with rst high at a clock edge, set state IDLE, ack_I=ack_D=0, mem_cen=mem_wen=0, mem_addr=mem_wdata=0, rdata_I=rdata_D=0, err=0, round-robin pointer to D and timeout counter to 0.
REQ-030 SHALL, on reset during BUSY or DONE, abandon the access without issuing ack.

Configuration
REQ-031 SHALL, with macro ARB_TIMEOUT_EN defined, count BUSY cycles; on reaching TIMEOUT_CYC without mem_ready, move to DONE, ack the owner with rdata=0, and set err until reset.
REQ-032 SHALL, without ARB_TIMEOUT_EN, stay in BUSY indefinitely until mem_ready, tie err to 0, and contain no counter logic.

Verification
REQ-033 SHALL cover a lone fetch: req_I=1, addr_I=0x40, mem_ready=1 in the first BUSY cycle, mem_rdata=0x00A00093 -> mem_addr=0x40, ack_I pulse 2 cycles after request, rdata_I=0x00A00093.
REQ-034 SHALL cover a simultaneous request after reset: req_I and req_D both high -> D served first, then I; repeated simultaneous requests alternate I, D, I.
REQ-035 SHALL cover a write: req_D=1, wen_D=1, addr_D=0x1000, wdata_D=0xDEADBEEF, mem_ready after 3 BUSY cycles -> mem_wen=1 for those 3 cycles, ack_D 1 cycle later, rdata_D unchanged.
REQ-036 SHALL cover reset in BUSY: rst pulsed during a D read -> no ack_D, state IDLE, all outputs 0, next simultaneous request grants D.
REQ-037 SHALL cover timeout with ARB_TIMEOUT_EN and TIMEOUT_CYC=16: mem_ready held 0 -> ack pulse after 16 BUSY cycles, rdata=0, err=1 until reset; without the macro, the arbiter stays in BUSY.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction-fetch port, data port, memory port
// and the sticky error flag. Only clk/rst stay outside the bundle.
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory model)
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        req_I;
    logic [31:0] addr_I;
    logic        ack_I;
    logic [31:0] rdata_I;

    // Data port
    logic        req_D;
    logic        wen_D;
    logic [31:0] addr_D;
    logic [31:0] wdata_D;
    logic        ack_D;
    logic [31:0] rdata_D;

    // Memory port
    logic        mem_cen;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Sticky timeout flag
    logic        err;

    modport slave (
        input  req_I, addr_I,
        input  req_D, wen_D, addr_D, wdata_D,
        input  mem_rdata, mem_ready,
        output ack_I, rdata_I,
        output ack_D, rdata_D,
        output mem_cen, mem_wen, mem_addr, mem_wdata,
        output err
    );

    modport master (
        output req_I, addr_I,
        output req_D, wen_D, addr_D, wdata_D,
        output mem_rdata, mem_ready,
        input  ack_I, rdata_I,
        input  ack_D, rdata_D,
        input  mem_cen, mem_wen, mem_addr, mem_wdata,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a single
// memory port. One access at a time: IDLE -> BUSY -> DONE -> IDLE.
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYC cycles without mem_ready; the owner is then acked with zero
// read data and the sticky err flag is raised until reset.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A timeout window shorter than one BUSY cycle is meaningless.
    if (TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("mem_arbiter: TIMEOUT_CYC must be at least 1");
    end

    state_t      state_q, state_d;

    // Latched access, captured at the grant edge. owner_d_q: 1 = data port.
    logic        owner_d_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Round-robin preference: 1 = data port wins a tie. After each completion
    // it points away from the port just served.
    logic        prio_d_q;

    logic [31:0] rdata_i_q;
    logic [31:0] rdata_d_q;

    logic        any_req;
    logic        grant_d;
    logic        mem_done;
    logic        timeout_hit;

    assign any_req  = bus.req_I | bus.req_D;
    // Lone requester always wins; on a tie the preferred port wins.
    assign grant_d  = bus.req_D & (~bus.req_I | prio_d_q);
    assign mem_done = (state_q == S_BUSY) & bus.mem_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    assign timeout_hit = (state_q == S_BUSY) & ~bus.mem_ready & (cnt_q == CNT_LAST);

    // Counter advances on every BUSY cycle and clears whenever BUSY is left.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_BUSY && !mem_done && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUSY;
            S_BUSY:  if (mem_done || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant latching, read-data capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d_q <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            prio_d_q  <= 1'b1;
            rdata_i_q <= '0;
            rdata_d_q <= '0;
        end else begin
            if (state_q == S_IDLE && any_req) begin
                owner_d_q <= grant_d;
                wen_q     <= grant_d & bus.wen_D;
                addr_q    <= grant_d ? bus.addr_D : bus.addr_I;
                wdata_q   <= grant_d ? bus.wdata_D : '0;
            end
            if (mem_done || timeout_hit) begin
                prio_d_q <= ~owner_d_q;
                // A timed-out read returns zero; writes never touch rdata_D.
                if (!owner_d_q) begin
                    rdata_i_q <= mem_done ? bus.mem_rdata : '0;
                end else if (!wen_q) begin
                    rdata_d_q <= mem_done ? bus.mem_rdata : '0;
                end
            end
        end
    end

    // Outputs decoded from state; address/data hold their last latched value.
    always_comb begin
        bus.mem_cen   = (state_q == S_BUSY);
        bus.mem_wen   = (state_q == S_BUSY) & wen_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.ack_I     = (state_q == S_DONE) & ~owner_d_q;
        bus.ack_D     = (state_q == S_DONE) &  owner_d_q;
        bus.rdata_I   = rdata_i_q;
        bus.rdata_D   = rdata_d_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 ns after the
// rising edge; outputs are checked at the same point.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic exp_d;
    logic [31:0] val;

    initial begin
        bus.req_I     = 1'b0;
        bus.addr_I    = '0;
        bus.req_D     = 1'b0;
        bus.wen_D     = 1'b0;
        bus.addr_D    = '0;
        bus.wdata_D   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // ---- reset state ----
        chk("rst_ack_I",    {31'd0, bus.ack_I},   32'd0);
        chk("rst_ack_D",    {31'd0, bus.ack_D},   32'd0);
        chk("rst_mem_cen",  {31'd0, bus.mem_cen}, 32'd0);
        chk("rst_mem_wen",  {31'd0, bus.mem_wen}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr,  32'd0);
        chk("rst_mem_wdata",bus.mem_wdata, 32'd0);
        chk("rst_rdata_I",  bus.rdata_I,   32'd0);
        chk("rst_rdata_D",  bus.rdata_D,   32'd0);
        chk("rst_err",      {31'd0, bus.err},     32'd0);

        // ---- lone fetch (pointer prefers D, I still granted) ----
        bus.req_I = 1'b1; bus.addr_I = 32'h40;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A00093;
        step();
        chk("fetch_busy_cen",  {31'd0, bus.mem_cen}, 32'd1);
        chk("fetch_busy_addr", bus.mem_addr, 32'h40);
        chk("fetch_busy_wen",  {31'd0, bus.mem_wen}, 32'd0);
        chk("fetch_busy_ack",  {31'd0, bus.ack_I},   32'd0);
        step();
        chk("fetch_ack_I",   {31'd0, bus.ack_I},   32'd1);
        chk("fetch_ack_D",   {31'd0, bus.ack_D},   32'd0);
        chk("fetch_rdata_I", bus.rdata_I, 32'h00A00093);
        chk("fetch_done_cen",{31'd0, bus.mem_cen}, 32'd0);
        $display("txn lone_fetch addr=%h rdata_I=%h", 32'h40, bus.rdata_I);
        bus.req_I = 1'b0; bus.mem_ready = 1'b0;
        step();
        chk("fetch_idle_ack",  {31'd0, bus.ack_I}, 32'd0);
        chk("fetch_idle_addr", bus.mem_addr, 32'h40);

        // ---- simultaneous requests after reset: D, I, D, I ----
        pulse_reset();
        bus.req_I = 1'b1; bus.addr_I = 32'h100;
        bus.req_D = 1'b1; bus.wen_D = 1'b0; bus.addr_D = 32'h200;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            val   = 32'hA000_0000 + 32'(k);
            bus.mem_rdata = val;
            step();
            chk("rr_busy_addr", bus.mem_addr, exp_d ? 32'h200 : 32'h100);
            step();
            chk("rr_ack_D", {31'd0, bus.ack_D}, {31'd0, exp_d});
            chk("rr_ack_I", {31'd0, bus.ack_I}, {31'd0, ~exp_d});
            chk("rr_rdata", exp_d ? bus.rdata_D : bus.rdata_I, val);
            $display("txn rr k=%0d owner=%s rdata=%h", k, exp_d ? "D" : "I", val);
            step();
            chk("rr_idle_cen", {31'd0, bus.mem_cen}, 32'd0);
        end
        bus.req_I = 1'b0; bus.req_D = 1'b0; bus.mem_ready = 1'b0;
        step();

        // ---- write with 3 BUSY cycles ----
        bus.req_D = 1'b1; bus.wen_D = 1'b1;
        bus.addr_D = 32'h1000; bus.wdata_D = 32'hDEADBEEF;
        bus.mem_rdata = 32'h5555_5555;
        step();
        chk("wr_b1_wen",   {31'd0, bus.mem_wen}, 32'd1);
        chk("wr_b1_addr",  bus.mem_addr,  32'h1000);
        chk("wr_b1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        step();
        chk("wr_b2_wen", {31'd0, bus.mem_wen}, 32'd1);
        chk("wr_b2_ack", {31'd0, bus.ack_D},   32'd0);
        step();
        bus.mem_ready = 1'b1;
        chk("wr_b3_wen", {31'd0, bus.mem_wen}, 32'd1);
        step();
        chk("wr_ack_D",   {31'd0, bus.ack_D},   32'd1);
        chk("wr_done_wen",{31'd0, bus.mem_wen}, 32'd0);
        chk("wr_rdata_D", bus.rdata_D, 32'hA000_0002);
        $display("txn write addr=%h wdata=%h", 32'h1000, 32'hDEADBEEF);
        bus.req_D = 1'b0; bus.wen_D = 1'b0; bus.mem_ready = 1'b0;
        step();

        // ---- reset during a D read ----
        bus.req_D = 1'b1; bus.addr_D = 32'h300;
        step();
        chk("rb_busy_cen", {31'd0, bus.mem_cen}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.req_D = 1'b0;
        chk("rb_ack_D",    {31'd0, bus.ack_D},   32'd0);
        chk("rb_mem_cen",  {31'd0, bus.mem_cen}, 32'd0);
        chk("rb_mem_addr", bus.mem_addr, 32'd0);
        chk("rb_rdata_D",  bus.rdata_D,  32'd0);
        chk("rb_rdata_I",  bus.rdata_I,  32'd0);
        step();
        chk("rb_no_late_ack", {31'd0, bus.ack_D}, 32'd0);
        $display("txn reset_in_busy addr=%h", 32'h300);

        bus.req_I = 1'b1; bus.addr_I = 32'h600;
        bus.req_D = 1'b1; bus.addr_D = 32'h700;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        step();
        chk("rb_grant_D_addr", bus.mem_addr, 32'h700);
        step();
        chk("rb_ack_D2",   {31'd0, bus.ack_D}, 32'd1);
        chk("rb_rdata_D2", bus.rdata_D, 32'h77);
        $display("txn post_reset_tie owner=D rdata=%h", bus.rdata_D);
        bus.req_I = 1'b0; bus.req_D = 1'b0; bus.mem_ready = 1'b0;
        step();

        // ---- prime rdata_I, then stall memory ----
        bus.req_I = 1'b1; bus.addr_I = 32'h800;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        step();
        step();
        chk("pre_rdata_I", bus.rdata_I, 32'hCAFE_0001);
        bus.req_I = 1'b0; bus.mem_ready = 1'b0;
        step();

        bus.req_I = 1'b1; bus.addr_I = 32'h900; bus.mem_rdata = 32'h1234_5678;
        step();
        for (int i = 2; i <= 16; i++) begin
            step();
            chk("stall_cen",   {31'd0, bus.mem_cen}, 32'd1);
            chk("stall_ack_I", {31'd0, bus.ack_I},   32'd0);
        end
`ifdef ARB_TIMEOUT_EN
        step();
        chk("to_ack_I",   {31'd0, bus.ack_I}, 32'd1);
        chk("to_rdata_I", bus.rdata_I, 32'd0);
        chk("to_err",     {31'd0, bus.err},   32'd1);
        $display("txn timeout addr=%h err=%0d", 32'h900, bus.err);
        bus.req_I = 1'b0;
        step();
        chk("to_err_hold1", {31'd0, bus.err},   32'd1);
        chk("to_ack_off",   {31'd0, bus.ack_I}, 32'd0);
        step();
        chk("to_err_hold2", {31'd0, bus.err}, 32'd1);
        pulse_reset();
        chk("to_err_clr", {31'd0, bus.err}, 32'd0);
`else
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nto_cen",   {31'd0, bus.mem_cen}, 32'd1);
            chk("nto_ack_I", {31'd0, bus.ack_I},   32'd0);
            chk("nto_err",   {31'd0, bus.err},     32'd0);
        end
        $display("txn stall_no_timeout addr=%h still_busy=%0d", 32'h900, bus.mem_cen);
        bus.req_I = 1'b0;
        pulse_reset();
        chk("nto_rst_cen", {31'd0, bus.mem_cen}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
